timer: RTL and testbench

- Programmable one-shot down-counter that raises a single-cycle interrupt when a loaded count expires.
- Software or controller logic presents a count on `set`, pulses `load`, and receives `irq` after that many ticks.
- Used as the delay/phase timer for the controller FSM.
- Optional periodic auto-reload mode.

---
 rtl/timer_pkg.sv | 9 +
 rtl/timer_if.sv | 17 +
 rtl/timer_prescaler.sv | 46 ++++
 rtl/timer.sv | 93 +++++++++
 tb/tb_timer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer block.
package timer_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 1;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/timer_if.sv
// Control/status bundle between a timer and whoever loads it.
interface timer_if
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] set;
  logic             load;
  logic             irq;
  logic             busy;
  logic [WIDTH-1:0] count;

  modport master (output set, output load, input irq, input busy, input count);
  modport slave  (input set, input load, output irq, output busy, output count);

endinterface

// File: rtl/timer_prescaler.sv
// Modulo-PRESCALE tick generator; restarts its phase on clear or when disabled.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear_i};
      assign tick_o        = enable_i;
    end else begin : g_div
      localparam logic [15:0] LAST = 16'(PRESCALE - 1);

      logic [15:0] cnt_q, cnt_d;

      assign tick_o = enable_i && (cnt_q == LAST);

      // Phase is zero on the load edge so the first tick lands PRESCALE edges later.
      always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i || tick_o) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/timer.sv
// One-shot down-counter with a registered single-cycle expiry pulse.
// Defining TIMER_AUTORELOAD_EN makes it periodic, reloading the last nonzero set value.
module timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input logic clk,
  input logic rst_n,
  timer_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             irq_q, irq_d;
  logic             tick;

`ifdef TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (bus.load),
    .enable_i (busy_q),
    .tick_o   (tick)
  );

  // Load takes priority over an expiry tick on the same edge, so no irq is raised then.
  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    irq_d   = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      if (bus.set != '0) begin
        count_d = bus.set;
        busy_d  = 1'b1;
      end else begin
        count_d = '0;
        busy_d  = 1'b0;
      end
`ifdef TIMER_AUTORELOAD_EN
      reload_d = bus.set;
`endif
    end else if (busy_q && tick) begin
      if (count_q == WIDTH'(1)) begin
        irq_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
        busy_d  = 1'b0;
`endif
      end else if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
    end
  end

`ifdef TIMER_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench: PRESCALE=1 and PRESCALE=3 timers driven in lockstep against an arithmetic model.
// Honours TIMER_AUTORELOAD_EN in the model the same way the RTL does.
module tb_timer;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  int edgeNum  = 0;
  int loadEdge = 0;
  int loadVal  = 0;

  timer_if #(.WIDTH(8)) bus1 ();
  timer_if #(.WIDTH(8)) bus3 ();

  timer #(.WIDTH(8), .PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  timer #(.WIDTH(8), .PRESCALE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  // Expected outputs follow from elapsed edges since the last load: ticks = elapsed / prescale.
  function automatic void modelPredict(input int p, output logic eBusy, output logic eIrq,
                                       output int eCount);
    int d;
    eBusy  = 1'b0;
    eIrq   = 1'b0;
    eCount = 0;
    if (loadVal != 0) begin
      d = edgeNum - loadEdge;
`ifdef TIMER_AUTORELOAD_EN
      eBusy  = 1'b1;
      eCount = loadVal - ((d / p) % loadVal);
      eIrq   = (d > 0) && ((d % (loadVal * p)) == 0);
`else
      if (d < loadVal * p) begin
        eBusy  = 1'b1;
        eCount = loadVal - (d / p);
      end else if (d == loadVal * p) begin
        eIrq = 1'b1;
      end
`endif
    end
  endfunction

  task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s edge=%0d observed=%0d expected=%0d", tag, edgeNum, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic eBusy, eIrq;
    int   eCount;
    modelPredict(1, eBusy, eIrq, eCount);
    checkOne("p1_irq",   16'(bus1.irq),   16'(eIrq));
    checkOne("p1_busy",  16'(bus1.busy),  16'(eBusy));
    checkOne("p1_count", 16'(bus1.count), 16'(eCount));
    modelPredict(3, eBusy, eIrq, eCount);
    checkOne("p3_irq",   16'(bus3.irq),   16'(eIrq));
    checkOne("p3_busy",  16'(bus3.busy),  16'(eBusy));
    checkOne("p3_count", 16'(bus3.count), 16'(eCount));
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input count_t s);
    rst_n     = r;
    bus1.load = ld;
    bus1.set  = s;
    bus3.load = ld;
    bus3.set  = s;
    @(posedge clk);
    edgeNum++;
    if (r) begin
      loadVal = 0;
    end else if (ld) begin
      loadEdge = edgeNum;
      loadVal  = int'(s);
    end
    #2;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, count_t'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    logic   r, ld;
    count_t s;
    rst_n     = 1'b1;
    bus1.load = 1'b0;
    bus1.set  = '0;
    bus3.load = 1'b0;
    bus3.set  = '0;
    $display("[TB] starting timer bench");

    applyStimulus(1'b1, 1'b0, 8'd0);
    idle(5);

    applyStimulus(1'b0, 1'b1, 8'd7);
    idle(9);

    applyStimulus(1'b0, 1'b1, 8'd7);
    idle(3);
    applyStimulus(1'b0, 1'b1, 8'd3);
    idle(6);

    applyStimulus(1'b0, 1'b1, 8'd5);
    idle(1);
    applyStimulus(1'b0, 1'b1, 8'd0);
    idle(10);

    applyStimulus(1'b0, 1'b1, 8'd2);
    idle(1);
    applyStimulus(1'b0, 1'b1, 8'd4);
    idle(14);

    applyStimulus(1'b0, 1'b1, 8'd2);
    idle(20);
    applyStimulus(1'b0, 1'b1, 8'd0);
    idle(4);

    applyStimulus(1'b0, 1'b1, 8'd2);
    idle(4);
    applyStimulus(1'b1, 1'b0, 8'd0);
    idle(3);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 8'd1);
    end
    idle(5);

    applyStimulus(1'b0, 1'b1, 8'd255);
    idle(10);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 5) == 0);
      s  = ld ? count_t'($urandom_range(0, 9)) : count_t'($urandom_range(0, 255));
      applyStimulus(r, ld, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
